div_io_ctrl: RTL and testbench



---
 rtl/div_io_ctrl_pkg.sv | 15 +
 rtl/div_io_ctrl_sat_counter.sv | 35 +++
 rtl/div_io_ctrl.sv | 164 ++++++++++++++++
 tb/tb_div_io_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_io_ctrl_pkg.sv
// Shared definitions for the divider request/response front-end: FSM state encoding
// (shared with control_unit/datapath) and default operand/latency widths.
package div_io_ctrl_pkg;

  localparam int DIV_WIDTH = 4;
  localparam int DIV_LAT_W = 6;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_BUSY   = 2'd2,
    ST_HOLD   = 2'd3
  } div_state_e;

endpackage

// File: rtl/div_io_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over enable);
// sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int LAT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  output logic [LAT_W-1:0] count
);

  logic [LAT_W-1:0] count_q;
  logic [LAT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != {LAT_W{1'b1}})) begin
      count_d = count_q + LAT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/div_io_ctrl.sv
// Valid/ready front-end for the integer divider: registers operands, pulses go, captures the
// result on done and holds it until consumed. Optional macro: DIV_ZERO_BYPASS_EN.
module div_io_ctrl
  import div_io_ctrl_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int LAT_W = DIV_LAT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             go,
  output logic [WIDTH-1:0] x_op,
  output logic [WIDTH-1:0] y_op,
  input  logic             done,
  input  logic [WIDTH-1:0] q_in,
  input  logic [WIDTH-1:0] r_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic [LAT_W-1:0] last_latency
);

  div_state_e       state_q, state_d;
  logic             in_ready_q, in_ready_d;
  logic             go_q, go_d;
  logic [WIDTH-1:0] x_op_q, x_op_d;
  logic [WIDTH-1:0] y_op_q, y_op_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             div_by_zero_q, div_by_zero_d;
  logic [LAT_W-1:0] last_latency_q, last_latency_d;
  logic             lat_clear;
  logic             lat_enable;
  logic [LAT_W-1:0] lat_cnt;

  sat_counter #(
    .LAT_W (LAT_W)
  ) u_lat_cnt (
    .clk    (clk),
    .rst    (rst),
    .clear  (lat_clear),
    .enable (lat_enable),
    .count  (lat_cnt)
  );

  always_comb begin
    state_d        = state_q;
    in_ready_d     = in_ready_q;
    go_d           = 1'b0;
    x_op_d         = x_op_q;
    y_op_d         = y_op_q;
    out_valid_d    = out_valid_q;
    quotient_d     = quotient_q;
    remainder_d    = remainder_q;
    div_by_zero_d  = div_by_zero_q;
    last_latency_d = last_latency_q;
    lat_clear      = 1'b0;
    lat_enable     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        in_ready_d = 1'b1;
        if (in_valid && in_ready_q) begin
          x_op_d     = dividend;
          y_op_d     = divisor;
          in_ready_d = 1'b0;
`ifdef DIV_ZERO_BYPASS_EN
          if (divisor == '0) begin
            state_d        = ST_HOLD;
            quotient_d     = {WIDTH{1'b1}};
            remainder_d    = dividend;
            div_by_zero_d  = 1'b1;
            last_latency_d = '0;
            out_valid_d    = 1'b1;
          end else begin
            state_d = ST_LAUNCH;
            go_d    = 1'b1;
          end
`else
          state_d = ST_LAUNCH;
          go_d    = 1'b1;
`endif
        end
      end

      // done is deliberately not looked at here: a level-held done from the previous
      // operation must not be mistaken for completion of this one.
      ST_LAUNCH: begin
        lat_clear = 1'b1;
        state_d   = ST_BUSY;
      end

      ST_BUSY: begin
        lat_enable = 1'b1;
        if (done) begin
          quotient_d     = q_in;
          remainder_d    = r_in;
          div_by_zero_d  = 1'b0;
          last_latency_d = lat_cnt;
          out_valid_d    = 1'b1;
          state_d        = ST_HOLD;
        end
      end

      ST_HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = ST_IDLE;
        end
      end

      default: begin
        state_d     = ST_IDLE;
        in_ready_d  = 1'b0;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= ST_IDLE;
      in_ready_q     <= 1'b0;
      go_q           <= 1'b0;
      x_op_q         <= '0;
      y_op_q         <= '0;
      out_valid_q    <= 1'b0;
      quotient_q     <= '0;
      remainder_q    <= '0;
      div_by_zero_q  <= 1'b0;
      last_latency_q <= '0;
    end else begin
      state_q        <= state_d;
      in_ready_q     <= in_ready_d;
      go_q           <= go_d;
      x_op_q         <= x_op_d;
      y_op_q         <= y_op_d;
      out_valid_q    <= out_valid_d;
      quotient_q     <= quotient_d;
      remainder_q    <= remainder_d;
      div_by_zero_q  <= div_by_zero_d;
      last_latency_q <= last_latency_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign go           = go_q;
  assign x_op         = x_op_q;
  assign y_op         = y_op_q;
  assign out_valid    = out_valid_q;
  assign quotient     = quotient_q;
  assign remainder    = remainder_q;
  assign div_by_zero  = div_by_zero_q;
  assign last_latency = last_latency_q;

endmodule

// File: tb/tb_div_io_ctrl.sv
// Self-checking bench for div_io_ctrl: transaction-level reference model compared every cycle,
// plus directed scenarios with hand-computed results. Honours DIV_ZERO_BYPASS_EN if defined.
module tb_div_io_ctrl;

  localparam int W_READY  = 0;
  localparam int W_GO     = 1;
  localparam int W_OVALID = 2;

  logic       clk       = 1'b0;
  logic       rst       = 1'b0;
  logic       in_valid  = 1'b0;
  logic       in_ready;
  logic [3:0] dividend  = '0;
  logic [3:0] divisor   = '0;
  logic       go;
  logic [3:0] x_op;
  logic [3:0] y_op;
  logic       done      = 1'b0;
  logic [3:0] q_in      = '0;
  logic [3:0] r_in      = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [3:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;
  logic [5:0] last_latency;

  int total = 0;
  int bad   = 0;

  logic [3:0] curA = '0;
  logic [3:0] curB = '0;

  // reference model: what the outputs must show, derived from requests and handshakes
  logic       mInReady  = 1'b0;
  logic       mGo       = 1'b0;
  logic       mOutValid = 1'b0;
  logic       mDbz      = 1'b0;
  logic [3:0] mX = '0, mY = '0, mQ = '0, mR = '0;
  logic [5:0] mLat = '0;
  bit         computing = 1'b0;
  int         busyCnt = 0;

  always #5 clk = ~clk;

  div_io_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .dividend     (dividend),
    .divisor      (divisor),
    .go           (go),
    .x_op         (x_op),
    .y_op         (y_op),
    .done         (done),
    .q_in         (q_in),
    .r_in         (r_in),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .quotient     (quotient),
    .remainder    (remainder),
    .div_by_zero  (div_by_zero),
    .last_latency (last_latency)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        mInReady = 1'b0; mGo = 1'b0; mOutValid = 1'b0; mDbz = 1'b0;
        mX = '0; mY = '0; mQ = '0; mR = '0; mLat = '0;
        computing = 1'b0; busyCnt = 0;
      end else if (in_valid && mInReady) begin
        mX = dividend;
        mY = divisor;
        mInReady = 1'b0;
`ifdef DIV_ZERO_BYPASS_EN
        if (divisor == 4'd0) begin
          mQ = 4'hF; mR = dividend; mDbz = 1'b1; mLat = '0; mOutValid = 1'b1;
        end else begin
          mGo = 1'b1;
        end
`else
        mGo = 1'b1;
`endif
      end else if (mGo) begin
        mGo = 1'b0;
        computing = 1'b1;
        busyCnt = 0;
      end else if (computing) begin
        if (done) begin
          mQ = (mY == 4'd0) ? 4'hF : mX / mY;
          mR = (mY == 4'd0) ? mX : mX % mY;
          mDbz = 1'b0;
          mLat = (busyCnt > 63) ? 6'd63 : 6'(busyCnt);
          mOutValid = 1'b1;
          computing = 1'b0;
        end else begin
          busyCnt++;
        end
      end else if (mOutValid) begin
        if (out_ready) begin
          mOutValid = 1'b0;
          mInReady = 1'b1;
        end
      end else if (!mInReady) begin
        mInReady = 1'b1;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      #1;
      checkOutput("m_in_ready",     32'(in_ready),     32'(mInReady));
      checkOutput("m_go",           32'(go),           32'(mGo));
      checkOutput("m_out_valid",    32'(out_valid),    32'(mOutValid));
      checkOutput("m_x_op",         32'(x_op),         32'(mX));
      checkOutput("m_y_op",         32'(y_op),         32'(mY));
      checkOutput("m_quotient",     32'(quotient),     32'(mQ));
      checkOutput("m_remainder",    32'(remainder),    32'(mR));
      checkOutput("m_div_by_zero",  32'(div_by_zero),  32'(mDbz));
      checkOutput("m_last_latency", 32'(last_latency), 32'(mLat));
    end
  end

  function automatic bit condMet(input int which);
    case (which)
      W_READY:  return in_ready === 1'b1;
      W_GO:     return go === 1'b1;
      default:  return out_valid === 1'b1;
    endcase
  endfunction

  task automatic waitCond(input int which, input int budget, input string name);
    int n = 0;
    while (!condMet(which) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput({"reached_", name}, 32'(condMet(which)), 1);
  endtask

  // present a request and return at the negedge after it was accepted
  task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b);
    waitCond(W_READY, 8, "in_ready");
    curA = a;
    curB = b;
    dividend = a;
    divisor = b;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // called in the LAUNCH cycle; done is raised after busyLow BUSY cycles with done low
  task automatic finishDivision(input int busyLow);
    checkOutput("go_pulse", 32'(go), 1);
    repeat (busyLow + 1) @(negedge clk);
    done = 1'b1;
    q_in = (curB == 4'd0) ? 4'hF : curA / curB;
    r_in = (curB == 4'd0) ? curA : curA % curB;
    @(negedge clk);
    done = 1'b0;
    checkOutput("result_valid", 32'(out_valid), 1);
  endtask

  task automatic consume(input int holdCycles);
    repeat (holdCycles) @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput("released", 32'(out_valid), 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("rst_in_ready",  32'(in_ready), 0);
    checkOutput("rst_go",        32'(go), 0);
    checkOutput("rst_out_valid", 32'(out_valid), 0);
    checkOutput("rst_quotient",  32'(quotient), 0);
    checkOutput("rst_latency",   32'(last_latency), 0);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("ready_after_rst", 32'(in_ready), 1);

    $display("[TB] 13/4 with 6 busy cycles");
    applyStimulus(4'd13, 4'd4);
    finishDivision(6);
    checkOutput("q_13_4",   32'(quotient), 3);
    checkOutput("r_13_4",   32'(remainder), 1);
    checkOutput("lat_13_4", 32'(last_latency), 6);
    consume(2);
    checkOutput("ready_after_13_4", 32'(in_ready), 1);

    $display("[TB] backpressure on 15/5");
    applyStimulus(4'd15, 4'd5);
    finishDivision(4);
    dividend = 4'd1;
    divisor = 4'd1;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      checkOutput("bp_q",     32'(quotient), 3);
      checkOutput("bp_r",     32'(remainder), 0);
      checkOutput("bp_ready", 32'(in_ready), 0);
      checkOutput("bp_x_op",  32'(x_op), 15);
      @(negedge clk);
    end
    in_valid = 1'b0;
    consume(0);

    $display("[TB] stale done through launch of 9/2");
    done = 1'b1;
    q_in = 4'd3;
    r_in = 4'd0;
    applyStimulus(4'd9, 4'd2);
    checkOutput("stale_go", 32'(go), 1);
    @(negedge clk);
    checkOutput("stale_no_capture", 32'(out_valid), 0);
    done = 1'b0;
    @(negedge clk);
    done = 1'b1;
    q_in = 4'd4;
    r_in = 4'd1;
    @(negedge clk);
    done = 1'b0;
    checkOutput("stale_valid", 32'(out_valid), 1);
    checkOutput("q_9_2",   32'(quotient), 4);
    checkOutput("r_9_2",   32'(remainder), 1);
    checkOutput("lat_9_2", 32'(last_latency), 1);
    consume(0);

    $display("[TB] latency saturation on 11/3");
    applyStimulus(4'd11, 4'd3);
    finishDivision(70);
    checkOutput("q_11_3",   32'(quotient), 3);
    checkOutput("r_11_3",   32'(remainder), 2);
    checkOutput("lat_sat",  32'(last_latency), 63);
    consume(0);

    $display("[TB] reset during busy of 7/3");
    applyStimulus(4'd7, 4'd3);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("mid_rst_ready", 32'(in_ready), 0);
    checkOutput("mid_rst_valid", 32'(out_valid), 0);
    checkOutput("mid_rst_x_op",  32'(x_op), 0);
    checkOutput("mid_rst_y_op",  32'(y_op), 0);
    checkOutput("mid_rst_q",     32'(quotient), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    applyStimulus(4'd8, 4'd2);
    finishDivision(3);
    checkOutput("q_8_2",   32'(quotient), 4);
    checkOutput("r_8_2",   32'(remainder), 0);
    checkOutput("lat_8_2", 32'(last_latency), 3);
    consume(1);

    $display("[TB] zero divisor 6/0");
    applyStimulus(4'd6, 4'd0);
`ifdef DIV_ZERO_BYPASS_EN
    checkOutput("dz_go",    32'(go), 0);
    checkOutput("dz_valid", 32'(out_valid), 1);
    checkOutput("dz_q",     32'(quotient), 15);
    checkOutput("dz_r",     32'(remainder), 6);
    checkOutput("dz_flag",  32'(div_by_zero), 1);
    checkOutput("dz_lat",   32'(last_latency), 0);
    repeat (2) begin
      @(negedge clk);
      checkOutput("dz_go_quiet", 32'(go), 0);
    end
    consume(0);
`else
    finishDivision(2);
    checkOutput("dz_q",    32'(quotient), 15);
    checkOutput("dz_r",    32'(remainder), 6);
    checkOutput("dz_flag", 32'(div_by_zero), 0);
    consume(0);
`endif

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
